// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, latched request, counter width.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word array behind the responder: combinational read, per-lane synchronous write, no reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    lane_en,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && lane_en[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder with valid/ready request and response channels.
// Build option: define DMEM_BYTE_WRITE_EN to honour req_be on stores.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  state_t           state, state_nx;
  req_t             req_q;
  logic [CNT_W-1:0] cnt;
  logic [32:0]      offset;
  logic             err;
  logic             fire;
  logic [3:0]       lane_en;
  logic [31:0]      rd_word;

  // 33-bit offset: an address below BASE_ADDR wraps to >= 2^32, so a single compare covers both bounds.
  assign offset = {1'b0, req_q.addr} - {1'b0, BASE_ADDR};
  assign err    = (req_q.addr[1:0] != 2'b00) || (offset >= SPAN);
  assign fire   = (state == WAIT) && (cnt == '0);

`ifdef DMEM_BYTE_WRITE_EN
  assign lane_en = req_q.be;
`else
  // Byte enables are latched but every lane is forced on.
  assign lane_en = req_q.be | 4'hF;
`endif

  assign req_ready  = rst && (state == IDLE);
  assign resp_valid = (state == RESP);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      req_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        req_q <= '{write: req_write, addr: req_addr, wdata: req_wdata, be: req_be};
        cnt   <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (fire) begin
        resp_err   <= err;
        resp_rdata <= (err || req_q.write) ? 32'h0 : rd_word;
      end
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .we      (fire && req_q.write && !err),
    .lane_en (lane_en),
    .idx     (offset[AW+1:2]),
    .wdata   (req_q.wdata),
    .rdata   (rd_word)
  );

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the pipeline's data-memory interface: accepts one load/store request at a time from the Memory stage over a valid/ready handshake, performs it against an internal word array after a fixed latency, and returns data plus an error flag over a valid/ready response channel. It replaces the zero-latency data store behind the Memory stage and lets the pipeline be exercised against realistic memory stalls.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array (power of two).
- `BASE_ADDR`, 32'h0000_2000: byte address of word 0.
- `LATENCY`, 2: cycles from request acceptance to response; legal range 1..15.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  Memory stage presents a request.
- `req_ready`  out  1  responder can accept a request this cycle.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `req_be`  in  4  byte enables, bit i = byte lane i (little-endian).
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  Memory stage consumes response.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch write/addr/wdata/be into request registers, load counter with LATENCY-1, go to WAIT.
- WAIT: `req_ready`=0. Counter decrements each cycle; when counter==0, perform the access and go to RESP on the same edge.
- Access: error if `addr[1:0]`!=0 or addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH_WORDS (compute with 33-bit arithmetic, no wrap). On error: no array write, `resp_rdata`=0, `resp_err`=1. Load: `resp_rdata` = word at index (addr-BASE_ADDR)>>2. Store: update enabled lanes, `resp_rdata`=0.
- RESP: `resp_valid`=1, `resp_rdata`/`resp_err` held stable until `resp_valid`&&`resp_ready`; then go to IDLE. No request accepted in the same cycle as the response handshake (one dead cycle, no bypass).
- Request inputs ignored outside IDLE; `req_valid` dropped without acceptance has no effect.
- Array contents are not reset; loads of never-written words return X in simulation.

## Timing
- Reset values: `req_ready`=0 while `rst` low, 1 in first cycle after release (state IDLE); `resp_valid`=0, `resp_rdata`=0, `resp_err`=0; counter 0.
- Accept at edge T -> `resp_valid` high after edge T+LATENCY.
- Store commits to array at edge T+LATENCY, not at acceptance; a load accepted after a store's response always sees the stored data.
- Throughput: one request per LATENCY+2 cycles with `resp_ready` tied high.
- Reset asserted during WAIT: request discarded, pending store never committed. During RESP: response dropped.
- `resp_ready` high while `resp_valid` low: ignored.

## Configuration
- `DMEM_BYTE_WRITE_EN` defined: `req_be` honoured; store with `req_be`=0 is a legal no-op (no error, no change).
- Not defined: `req_be` ignored, every store writes all four lanes.

## Structure
- `dmem_pkg`: FSM state enum (IDLE/WAIT/RESP), request struct type (write, addr, wdata, be), latency counter width constant.
- Sub-module `dmem_array`: DEPTH_WORDS x 32 array, combinational read, synchronous write with per-lane enables; no reset. Responder holds FSM, counter, request/response registers, range check.

## Test plan
- Store 32'hDEADBEEF to 32'h2000, then load 32'h2000 with LATENCY=2 -> each `resp_valid` 2 cycles after accept; load returns 32'hDEADBEEF, `resp_err`=0.
- With `DMEM_BYTE_WRITE_EN`: store 32'h11223344 be=4'hF, then 32'hAABBCCDD be=4'b0101 to 32'h2004 -> load returns 32'h11BB33DD; without macro -> 32'hAABBCCDD.
- Load 32'h2002 and load 32'h3000 (DEPTH 1024) -> `resp_err`=1, `resp_rdata`=0; a store to 32'h1FFC leaves array unchanged.
- Hold `resp_ready`=0 for 5 cycles -> `resp_valid`, data, err stable; `req_ready`=0 throughout; accept new request only the cycle after handshake.
- Store to 32'h2010, drop `rst` one cycle into WAIT, release -> outputs at reset values; subsequent load of 32'h2010 does not return the aborted data (pre-load a known value first to check).
- Back-to-back requests with `req_valid` held high, `resp_ready`=1 -> accepts spaced exactly LATENCY+2 cycles apart.
